// File: rtl/swsd_pkg.sv
// Shared constants and helpers for the sliding-window sequence detector.
package swsd_pkg;

   localparam int SWSD_MAX_LEN = 8;
   localparam int SWSD_CNT_W   = 8;
   localparam logic [7:0] SWSD_RST_PATTERN = 8'b0000_1011;
   localparam int SWSD_RST_LEN = 4;

   // Clamp a programmed length to the window depth.
   function automatic int unsigned swsd_clamp_len(input int unsigned len,
                                                  input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/param_window_seq_detector_if.sv
// Stream, configuration and status bundle for param_window_seq_detector.
// With SWSD_DONT_CARE_EN defined it also carries the cfg_mask field.
interface param_window_seq_detector_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
   logic               in;
   logic               in_valid;
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
`ifdef SWSD_DONT_CARE_EN
   logic [MAX_LEN-1:0] cfg_mask;
`endif
   logic               cnt_clr;
   logic               dec;
   logic [CNT_W-1:0]   hit_cnt;

   modport master (
`ifdef SWSD_DONT_CARE_EN
      output cfg_mask,
`endif
      output in, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      input  dec, hit_cnt
   );

   modport slave (
`ifdef SWSD_DONT_CARE_EN
      input  cfg_mask,
`endif
      input  in, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      output dec, hit_cnt
   );
endinterface

// File: rtl/swsd_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module swsd_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/param_window_seq_detector.sv
// Runtime-programmable sliding-window sequence detector with saturating hit count.
// Define SWSD_DONT_CARE_EN to add a per-bit compare mask (cfg_mask, 0 = don't-care).
module param_window_seq_detector
   import swsd_pkg::*;
#(
   parameter int                 MAX_LEN     = SWSD_MAX_LEN,
   parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
   parameter int                 CNT_W       = SWSD_CNT_W,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(SWSD_RST_PATTERN),
   parameter int                 RST_LEN     = SWSD_RST_LEN
) (
   input logic                        clk,
   input logic                        rst_n,
   param_window_seq_detector_if.slave bus
);
   typedef struct packed {
`ifdef SWSD_DONT_CARE_EN
      logic [MAX_LEN-1:0] mask;
`endif
      logic [MAX_LEN-1:0] pattern;
      logic [LEN_W-1:0]   len;
      logic               overlap;
   } cfg_t;

   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(swsd_clamp_len(RST_LEN, MAX_LEN));

   cfg_t               cfg_q, cfg_d;
   logic [MAX_LEN-1:0] window_q, window_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               dec_q, dec_d;
   logic               hit;
   logic [MAX_LEN-1:0] len_mask, cmp_mask;

   // Stored len is already clamped, so it is len_eff directly.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         len_mask[i] = (LEN_W'(i) < cfg_q.len);
   end

`ifdef SWSD_DONT_CARE_EN
   assign cmp_mask = len_mask & cfg_q.mask;
`else
   assign cmp_mask = len_mask;
`endif

   always_comb begin
      cfg_d    = cfg_q;
      window_d = window_q;
      fill_d   = fill_q;
      hit      = 1'b0;
      if (bus.cfg_we) begin
         // A config load restarts the stream; a coincident input bit is dropped.
         cfg_d.pattern = bus.cfg_pattern;
         cfg_d.len     = LEN_W'(swsd_clamp_len(32'(bus.cfg_len), MAX_LEN));
         cfg_d.overlap = bus.cfg_overlap;
`ifdef SWSD_DONT_CARE_EN
         cfg_d.mask    = bus.cfg_mask;
`endif
         window_d = '0;
         fill_d   = '0;
      end else if (bus.in_valid) begin
         window_d = {window_q[MAX_LEN-2:0], bus.in};
         fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
         hit      = (cfg_q.len != '0) && (fill_d >= cfg_q.len) &&
                    (((window_d ^ cfg_q.pattern) & cmp_mask) == '0);
         if (hit && !cfg_q.overlap)
            fill_d = '0;
      end
      dec_d = hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q.pattern <= RST_PATTERN;
         cfg_q.len     <= LEN_RST;
         cfg_q.overlap <= 1'b1;
`ifdef SWSD_DONT_CARE_EN
         cfg_q.mask    <= '1;
`endif
         window_q      <= '0;
         fill_q        <= '0;
         dec_q         <= 1'b0;
      end else begin
         cfg_q    <= cfg_d;
         window_q <= window_d;
         fill_q   <= fill_d;
         dec_q    <= dec_d;
      end
   end

   logic [CNT_W-1:0] hit_cnt;

   swsd_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit),
      .clr   (bus.cnt_clr),
      .cnt   (hit_cnt)
   );

   assign bus.dec     = dec_q;
   assign bus.hit_cnt = hit_cnt;
endmodule
